spec_mem_tracker: RTL
=====================

// Module: spec_mem_tracker
// PURPOSE
//  Bus-side monitor that sits in front of the spec API mem ports. Observes the Ibex data bus
//  (req/gnt/rvalid) for one instruction and records up to two granules. Read data and write
//  address/wdata/be are recorded per granule. Drives spec mem_read_*/mem_write_* compare
//  values and read-data returns. Clears on instruction retire.
// PARAMETERS
//  MaxPending  2  max granted-but-unanswered requests (Ibex misaligned access overlaps two)
// PORTS
//  clk_i                 in   1   clock
//  rst_i                 in   1   synchronous reset, active-high
//  data_req_i            in   1   core data request
//  data_gnt_i            in   1   memory grant
//  data_we_i             in   1   request is write
//  data_addr_i           in   32  word-aligned request address
//  data_be_i             in   4   byte enables
//  data_wdata_i          in   32  write data
//  data_rvalid_i         in   1   response valid
//  data_rdata_i          in   32  response read data
//  data_err_i            in   1   response bus error
//  instr_ret_i           in   1   retire pulse; record is cleared after this cycle
//  rec_valid_o           out  1   >=1 granule recorded and nothing pending
//  mem_read_o            out  1   first granule was a read
//  mem_read_snd_gran_o   out  1   second granule was a read
//  mem_read_fst_addr_o   out  32  / mem_read_snd_addr_o  out 32
//  mem_read_fst_rdata_o  out  32  / mem_read_snd_rdata_o out 32
//  mem_write_o           out  1   first granule was a write
//  mem_write_snd_gran_o  out  1   second granule was a write
//  mem_write_fst_addr_o  out  32  / mem_write_snd_addr_o  out 32
//  mem_write_fst_wdata_o out  32  / mem_write_snd_wdata_o out 32
//  mem_write_fst_be_o    out  4   / mem_write_snd_be_o    out 4
//  bus_err_o             out  1   any recorded response had data_err_i
//  protocol_err_o        out  1   sticky tracker violation; cleared only by rst_i
// BEHAVIOUR
//  - Reset: all outputs 0; pending FIFO empty; granule count k=0; state IDLE.
//  - Grant: data_req_i&data_gnt_i pushes {we,addr,be,wdata} into in-order FIFO of depth MaxPending.
//    FIFO full on grant: request dropped, protocol_err_o set.
//  - Response: data_rvalid_i pops FIFO head. Head recorded in slot k (0=fst, 1=snd), then k++.
//    Reads store data_rdata_i; writes store grant-time wdata/be; addr from grant.
//    data_err_i sets bus_err_o (granule still recorded).
//    rvalid with empty FIFO, or k==2: protocol_err_o set, response discarded.
//  - Read and write in one record: protocol_err_o set. Both granules still recorded.
//  - All record outputs are registered: they update on the edge after rvalid (1-cycle latency).
//  - Grant and rvalid in same cycle: pop head, then push (FIFO may be full before edge).
//  - States: IDLE (k=0, FIFO empty); ACTIVE (FIFO non-empty); COMPLETE (FIFO empty, k>0).
//    IDLE->ACTIVE on grant; ACTIVE->COMPLETE on last pop with no concurrent push.
//    COMPLETE->ACTIVE on a new grant (second granule).
//    Any state->IDLE on instr_ret_i: clears k, record outputs, bus_err_o.
//  - rec_valid_o = (state==COMPLETE), registered.
//  - Retire with FIFO non-empty: protocol_err_o set, FIFO flushed.
//  - Retire with same-cycle grant: record cleared, grant belongs to next instruction.
//    That grant is pushed into the empty FIFO; state = ACTIVE.
//  - rst_i mid-access: everything returns to reset values next edge; in-flight responses
//    after reset count as rvalid-with-empty-FIFO.
// TESTING
//  - Aligned LW @0x1000, rdata 0xDEADBEEF, rvalid 3 cycles after gnt
//    -> 1 cycle after rvalid: mem_read_o=1, fst_addr=0x1000, fst_rdata=0xDEADBEEF.
//    Also snd_gran=0, rec_valid_o=1.
//  - Misaligned LW: grants 0x1000/be 1100 and 0x1004/be 0011 both before first rvalid
//    -> both read flags =1. Addrs 0x1000/0x1004; rdata in grant order; rec_valid_o only after 2nd rvalid.
//  - Misaligned SW wdata 0x11223344 / 0x55667788 with err on 2nd rvalid
//    -> mem_write_o=mem_write_snd_gran_o=1, wdata/be per granule, bus_err_o=1.
//  - instr_ret_i in same cycle as new grant @0x2000
//    -> record cleared, then new fst_addr=0x2000 after its rvalid; protocol_err_o=0.
//  - rvalid with no prior grant; third grant in one record
//    -> protocol_err_o=1 and stays 1 across instr_ret_i until rst_i.
//  - rst_i asserted between gnt and rvalid -> outputs 0 next edge.
//    The later rvalid sets protocol_err_o=1.

Source files
------------

// File: rtl/spec_mem_tracker.sv
// Bus-side recorder for one instruction's data accesses (up to two granules),
// presenting read/write compare values to the spec API mem ports.
module spec_mem_tracker #(
  parameter int MaxPending = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_gnt_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  input  logic        instr_ret_i,
  output logic        rec_valid_o,
  output logic        mem_read_o,
  output logic        mem_read_snd_gran_o,
  output logic [31:0] mem_read_fst_addr_o,
  output logic [31:0] mem_read_snd_addr_o,
  output logic [31:0] mem_read_fst_rdata_o,
  output logic [31:0] mem_read_snd_rdata_o,
  output logic        mem_write_o,
  output logic        mem_write_snd_gran_o,
  output logic [31:0] mem_write_fst_addr_o,
  output logic [31:0] mem_write_snd_addr_o,
  output logic [31:0] mem_write_fst_wdata_o,
  output logic [31:0] mem_write_snd_wdata_o,
  output logic [3:0]  mem_write_fst_be_o,
  output logic [3:0]  mem_write_snd_be_o,
  output logic        bus_err_o,
  output logic        protocol_err_o,
  output logic [1:0]  state_o
);

  // Handshake: a request is accepted in any cycle with data_req_i & data_gnt_i;
  // each data_rvalid_i answers the oldest accepted request, in order, and
  // cannot be back-pressured.

  localparam int PW = (MaxPending > 1) ? $clog2(MaxPending) : 1;
  localparam int CW = $clog2(MaxPending + 1);
  localparam logic [CW-1:0] FULL = CW'(MaxPending);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, push_ptr;
  logic [CW-1:0] count_q, count_d, count_mid;
  logic [1:0]    k_q, k_d;
  logic          bus_err_q, bus_err_d, perr_q, perr_d;
  logic          grant, pop, rec_en, push_en;

  logic          fifo_we    [MaxPending];
  logic [31:0]   fifo_addr  [MaxPending];
  logic [3:0]    fifo_be    [MaxPending];
  logic [31:0]   fifo_wdata [MaxPending];

  logic          slot_we   [2];
  logic [31:0]   slot_addr [2];
  logic [31:0]   slot_data [2];
  logic [3:0]    slot_be   [2];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MaxPending - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    grant     = data_req_i & data_gnt_i;
    pop       = data_rvalid_i && (count_q != '0);
    perr_d    = perr_q;
    bus_err_d = bus_err_q;
    k_d       = k_q;
    rec_en    = 1'b0;
    push_en   = 1'b0;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_mid = count_q;
    push_ptr  = wr_ptr_q;

    if (data_rvalid_i && (count_q == '0)) perr_d = 1'b1;

    // Pop happens before the same-cycle push, so a full FIFO can still accept.
    if (pop) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      count_mid = count_q - CW'(1);
      if (k_q == 2'd2) begin
        perr_d = 1'b1;
      end else begin
        rec_en = 1'b1;
        k_d    = k_q + 2'd1;
        if (data_err_i) bus_err_d = 1'b1;
        if ((k_q == 2'd1) && (fifo_we[rd_ptr_q] != slot_we[0])) perr_d = 1'b1;
      end
    end

    // Retire closes the record; a same-cycle grant starts the next instruction.
    if (instr_ret_i) begin
      if (count_mid != '0) perr_d = 1'b1;
      count_mid = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      k_d       = 2'd0;
      bus_err_d = 1'b0;
    end

    count_d  = count_mid;
    push_ptr = wr_ptr_d;
    if (grant) begin
      if (count_mid == FULL) begin
        perr_d = 1'b1;
      end else begin
        push_en  = 1'b1;
        count_d  = count_mid + CW'(1);
        wr_ptr_d = ptr_inc(push_ptr);
      end
    end

    if (count_d != '0)  state_d = ACTIVE;
    else if (k_d != '0) state_d = COMPLETE;
    else                state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      k_q       <= 2'd0;
      bus_err_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      k_q       <= k_d;
      bus_err_q <= bus_err_d;
      perr_q    <= perr_d;
    end
  end

  // Payload storage needs no reset: every output is qualified by k_q.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      fifo_we[push_ptr]    <= data_we_i;
      fifo_addr[push_ptr]  <= data_addr_i;
      fifo_be[push_ptr]    <= data_be_i;
      fifo_wdata[push_ptr] <= data_wdata_i;
    end
    if (rec_en) begin
      slot_we[k_q[0]]   <= fifo_we[rd_ptr_q];
      slot_addr[k_q[0]] <= fifo_addr[rd_ptr_q];
      slot_be[k_q[0]]   <= fifo_be[rd_ptr_q];
      slot_data[k_q[0]] <= fifo_we[rd_ptr_q] ? fifo_wdata[rd_ptr_q] : data_rdata_i;
    end
  end

  logic fst_v, snd_v;
  assign fst_v = (k_q != 2'd0);
  assign snd_v = (k_q == 2'd2);

  assign mem_read_o            = fst_v & ~slot_we[0];
  assign mem_read_snd_gran_o   = snd_v & ~slot_we[1];
  assign mem_read_fst_addr_o   = mem_read_o ? slot_addr[0] : '0;
  assign mem_read_snd_addr_o   = mem_read_snd_gran_o ? slot_addr[1] : '0;
  assign mem_read_fst_rdata_o  = mem_read_o ? slot_data[0] : '0;
  assign mem_read_snd_rdata_o  = mem_read_snd_gran_o ? slot_data[1] : '0;
  assign mem_write_o           = fst_v & slot_we[0];
  assign mem_write_snd_gran_o  = snd_v & slot_we[1];
  assign mem_write_fst_addr_o  = mem_write_o ? slot_addr[0] : '0;
  assign mem_write_snd_addr_o  = mem_write_snd_gran_o ? slot_addr[1] : '0;
  assign mem_write_fst_wdata_o = mem_write_o ? slot_data[0] : '0;
  assign mem_write_snd_wdata_o = mem_write_snd_gran_o ? slot_data[1] : '0;
  assign mem_write_fst_be_o    = mem_write_o ? slot_be[0] : '0;
  assign mem_write_snd_be_o    = mem_write_snd_gran_o ? slot_be[1] : '0;
  assign bus_err_o             = bus_err_q;
  assign protocol_err_o        = perr_q;
  assign rec_valid_o           = (state_q == COMPLETE);
  assign state_o               = state_q;

endmodule
